pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Central hazard and stall sequencer for the five-stage pipeline. Detects load-use hazards between the ID and EX stages, freezes the pipeline while a data-memory access waits on its ready handshake, and flushes IF/ID and ID/EX on taken branches, including branches that resolve during a freeze. It also keeps saturating stall and flush performance counters and latches a sticky error on memory timeout. It sits beside the Execute stage and drives the write-enable, bubble and flush controls of the PC and all pipeline registers.

## Interface
- MEM_TIMEOUT, 16, total frozen cycles allowed for one memory access before error (>= 2)
- CNT_WIDTH, 16, width of performance counters

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- ifIdRs  in  5  rs of instruction in ID
- ifIdRt  in  5  rt of instruction in ID
- ifIdUsesRt  in  1  ID instruction reads rt as a source
- idExMemRead  in  1  instruction in EX is a load
- idExRt  in  5  destination of load in EX
- branchTaken  in  1  branch resolved taken in EX this cycle
- memReq  in  1  MEM stage issuing a data access
- memReady  in  1  data memory completes access this cycle
- clearCounters  in  1  synchronous clear of both counters
- pcWrite  out  1  PC load enable
- ifIdWrite  out  1  IF/ID register load enable
- idExBubble  out  1  load NOP controls into ID/EX
- ifIdFlush  out  1  clear IF/ID to NOP
- idExFlush  out  1  clear ID/EX to NOP
- pipeFreeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- memError  out  1  sticky memory-timeout flag
- stallCycles  out  CNT_WIDTH  count of cycles with pcWrite=0
- flushCount  out  CNT_WIDTH  count of flush cycles

## Operation
- States: RUN, MEM_WAIT, ERROR. Registers: state, waitCount, pendingFlush, both counters, memError.
- freeze = (RUN & memReq & ~memReady) | (MEM_WAIT & ~memReady) | ERROR.
- loadUse = idExMemRead & (idExRt != 0) & ((idExRt == ifIdRs) | (ifIdUsesRt & (idExRt == ifIdRt))).
- flush = ~freeze & (branchTaken | pendingFlush).
- Output priority: rst > freeze > flush > loadUse > normal.
  - rst: pcWrite=0, ifIdWrite=0, idExBubble=1, ifIdFlush=1, idExFlush=1, pipeFreeze=0.
  - freeze: pcWrite=0, ifIdWrite=0, pipeFreeze=1, all others 0.
  - flush: pcWrite=1, ifIdWrite=1, ifIdFlush=1, idExFlush=1, idExBubble=0; any load-use hazard is ignored because the ID instruction is discarded.
  - loadUse: pcWrite=0, ifIdWrite=0, idExBubble=1.
  - normal: pcWrite=1, ifIdWrite=1, all others 0.
- Transitions:
  - RUN -> MEM_WAIT when memReq & ~memReady; waitCount loads 1.
  - MEM_WAIT & memReady -> RUN. Freeze is already released in that cycle.
  - MEM_WAIT & ~memReady & waitCount == MEM_TIMEOUT-1 -> ERROR; otherwise waitCount increments.
  - ERROR persists until rst; memError=1 while in ERROR.
- pendingFlush: set on any edge where freeze & branchTaken; cleared on an edge where flush=1.
- Counters:
  - stallCycles increments when pcWrite=0, rst=0 and state != ERROR.
  - flushCount increments when flush=1.
  - Both saturate at all-ones.
  - clearCounters zeroes both; it has lower priority than rst and wins over a same-cycle increment.
- Reset values: state=RUN, waitCount=0, pendingFlush=0, memError=0, counters=0.

## Timing
- All control outputs are combinational from inputs and registered state, with no latency. Register updates take effect on the next rising edge.
- Load-use stall lasts exactly one cycle. In the next cycle the load has advanced and the ID/EX register holds a NOP.
- Freeze span for one access: from the first cycle memReq & ~memReady through the last cycle before memReady=1. ERROR is entered after exactly MEM_TIMEOUT frozen cycles.
- memReq & memReady in the same cycle in RUN: no freeze, state stays RUN.
- Reset asserted mid-MEM_WAIT or in ERROR: RUN on the next edge, memError=0, pendingFlush=0.
- A branch during a freeze is flushed in the first unfrozen cycle, and only once, even if branchTaken stays high. flushCount increments by 1.

## Test plan
- Load-use: idExMemRead=1, idExRt=5, ifIdRs=5 -> one cycle of pcWrite=0, ifIdWrite=0, idExBubble=1. With idExRt=0 -> no stall.
- Branch vs hazard: branchTaken=1 with the same load-use hazard -> ifIdFlush=idExFlush=1, pcWrite=1, idExBubble=0; flushCount 0->1.
- Memory wait: memReq=1, memReady=0 for 3 cycles then memReady=1 -> pipeFreeze=1 for 3 cycles, released on the ready cycle; stallCycles=3.
- Timeout with MEM_TIMEOUT=4: memReady held 0 -> freeze for 4 cycles, memError=1 from cycle 5 onward; rst -> memError=0 and pcWrite=1 after reset deasserts.
- Branch during freeze: branchTaken=1 in the 2nd frozen cycle, then dropped -> no flush while frozen, a single-cycle flush in the ready cycle, flushCount=1.
- Counters: force stallCycles to all-ones -> holds (saturates). clearCounters=1 together with a stall -> both counters read 0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard and stall sequencer for the five-stage pipeline: load-use stalls, memory
// freeze with timeout, branch flushes (deferred across a freeze) and perf counters.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           ifIdRs,
  input  logic [4:0]           ifIdRt,
  input  logic                 ifIdUsesRt,
  input  logic                 idExMemRead,
  input  logic [4:0]           idExRt,
  input  logic                 branchTaken,
  input  logic                 memReq,
  input  logic                 memReady,
  input  logic                 clearCounters,
  output logic                 pcWrite,
  output logic                 ifIdWrite,
  output logic                 idExBubble,
  output logic                 ifIdFlush,
  output logic                 idExFlush,
  output logic                 pipeFreeze,
  output logic                 memError,
  output logic [CNT_WIDTH-1:0] stallCycles,
  output logic [CNT_WIDTH-1:0] flushCount
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  state_e               state_q, state_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 pend_flush_q, pend_flush_d;
  logic                 mem_error_q, mem_error_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze, load_use, flush;

  assign freeze = (state_q == RUN && memReq && !memReady)
               || (state_q == MEM_WAIT && !memReady)
               || (state_q == ERROR);

  // r0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign load_use = idExMemRead && (idExRt != 5'd0)
                 && ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));

  assign flush = !freeze && (branchTaken || pend_flush_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      pend_flush_q <= 1'b0;
      mem_error_q  <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pend_flush_q <= pend_flush_d;
      mem_error_q  <= mem_error_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (memReq && !memReady) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WW'(MEM_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    idExBubble = 1'b0;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    pipeFreeze = 1'b0;
    if (rst) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
    end else if (freeze) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      pipeFreeze = 1'b1;
    end else if (flush) begin
      // The ID instruction is discarded, so a load-use hazard against it is moot.
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (load_use) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
    end
  end

  always_comb begin
    pend_flush_d = pend_flush_q;
    if (flush)                      pend_flush_d = 1'b0;
    else if (freeze && branchTaken) pend_flush_d = 1'b1;

    mem_error_d = (state_d == ERROR);

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clearCounters) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pcWrite && state_q != ERROR && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (flush && flush_cnt_q != '1)
        flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign memError    = mem_error_q;
  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;

endmodule
